// File: rtl/wb_dbg_pkg.sv
// Shared command/response codes and FSM state encoding for the UART-to-Wishbone debug master.
package wb_dbg_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;

    localparam logic [7:0] RSP_OK  = 8'h2B;
    localparam logic [7:0] RSP_ERR = 8'h21;
    localparam logic [7:0] RSP_UNK = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADR,
        RX_DAT,
        BUS,
        TX,
        TX_WAIT
    } state_t;

endpackage

// File: rtl/dbg_shreg32.sv
// 32-bit byte-wide shift register, MSB-first in and out, with a 2-bit count of bytes moved.
// Priority: clr > load > shift_in > shift_out.
module dbg_shreg32
    import wb_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_dat,
    input  logic        shift_in,
    input  logic [7:0]  in_byte,
    input  logic        shift_out,
    output logic [31:0] q,
    output logic [1:0]  cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= load_dat;
            cnt <= '0;
        end else if (shift_in) begin
            q   <= {q[23:0], in_byte};
            cnt <= cnt + 2'd1;
        end else if (shift_out) begin
            q   <= {q[23:0], 8'h00};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/wb_dbg_master.sv
// Wishbone master driven by a UART byte stream: parses R/W commands, runs one 32-bit
// bus cycle, and returns the read data or a one-byte status through the transmitter.
module wb_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int bus_timeout = 1024,
    parameter int rx_timeout  = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy
);

    localparam int BW = (bus_timeout > 1) ? $clog2(bus_timeout) : 1;
    localparam int RW = (rx_timeout  > 1) ? $clog2(rx_timeout)  : 1;
    localparam logic [BW-1:0] BUS_LAST = BW'(bus_timeout - 1);
    localparam logic [RW-1:0] RX_LAST  = RW'(rx_timeout - 1);

    state_t         state, state_n;
    logic           we_r;
    logic [7:0]     rsp_byte;
    logic           rsp_multi;
    logic           tx_last;
    logic           tx_hold;
    logic [BW-1:0]  bus_cnt;
    logic [RW-1:0]  rx_cnt;

    logic [31:0]    adr_q, dat_q;
    logic [1:0]     adr_cnt, dat_cnt;

    logic           rx_take;
    logic           adr_clr, adr_shift;
    logic           dat_clr, dat_shift, dat_load, dat_pop;
    logic           we_set, we_val;
    logic           cyc_start, cyc_end;
    logic           rsp_set, rsp_multi_val;
    logic [7:0]     rsp_val;
    logic           tx_fire;
    logic           in_rx;

    assign in_rx   = (state == RX_ADR) || (state == RX_DAT);
    assign rx_take = rx_avail && !reset && ((state == IDLE) || in_rx);
    assign rx_ack  = rx_take;
    assign busy    = (state != IDLE);

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = wb_cyc_o && we_r;
    assign wb_sel_o = {4{wb_cyc_o}};

    dbg_shreg32 u_adr (
        .clk       (clk),
        .reset     (reset),
        .clr       (adr_clr),
        .load      (1'b0),
        .load_dat  (32'h0),
        .shift_in  (adr_shift),
        .in_byte   (rx_data),
        .shift_out (1'b0),
        .q         (adr_q),
        .cnt       (adr_cnt)
    );

    // Data register doubles as the read-response serialiser.
    dbg_shreg32 u_dat (
        .clk       (clk),
        .reset     (reset),
        .clr       (dat_clr),
        .load      (dat_load),
        .load_dat  (wb_dat_i),
        .shift_in  (dat_shift),
        .in_byte   (rx_data),
        .shift_out (dat_pop),
        .q         (dat_q),
        .cnt       (dat_cnt)
    );

    always_comb begin
        state_n       = state;
        adr_clr       = 1'b0;
        adr_shift     = 1'b0;
        dat_clr       = 1'b0;
        dat_shift     = 1'b0;
        dat_load      = 1'b0;
        dat_pop       = 1'b0;
        we_set        = 1'b0;
        we_val        = 1'b0;
        cyc_start     = 1'b0;
        cyc_end       = 1'b0;
        rsp_set       = 1'b0;
        rsp_val       = RSP_UNK;
        rsp_multi_val = 1'b0;
        tx_fire       = 1'b0;
        case (state)
            IDLE: begin
                if (rx_take) begin
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
                        state_n = RX_ADR;
                        we_set  = 1'b1;
                        we_val  = (rx_data == CMD_WRITE);
                        adr_clr = 1'b1;
                        dat_clr = 1'b1;
                    end else begin
                        state_n = TX;
                        rsp_set = 1'b1;
                        rsp_val = RSP_UNK;
                    end
                end
            end
            RX_ADR: begin
                if (rx_take) begin
                    adr_shift = 1'b1;
                    if (adr_cnt == 2'd3) begin
                        if (we_r) begin
                            state_n = RX_DAT;
                        end else begin
                            state_n   = BUS;
                            cyc_start = 1'b1;
                        end
                    end
                end else if (rx_cnt == RX_LAST) begin
                    state_n = IDLE;
                end
            end
            RX_DAT: begin
                if (rx_take) begin
                    dat_shift = 1'b1;
                    if (dat_cnt == 2'd3) begin
                        state_n   = BUS;
                        cyc_start = 1'b1;
                    end
                end else if (rx_cnt == RX_LAST) begin
                    state_n = IDLE;
                end
            end
            BUS: begin
                // err outranks ack; either outranks a coincident timeout.
                if (wb_err_i || (!wb_ack_i && bus_cnt == BUS_LAST)) begin
                    state_n = TX;
                    cyc_end = 1'b1;
                    rsp_set = 1'b1;
                    rsp_val = RSP_ERR;
                end else if (wb_ack_i) begin
                    state_n       = TX;
                    cyc_end       = 1'b1;
                    rsp_set       = 1'b1;
                    rsp_val       = RSP_OK;
                    rsp_multi_val = !we_r;
                    dat_load      = !we_r;
                end
            end
            TX: begin
                if (!tx_busy) begin
                    tx_fire = 1'b1;
                    dat_pop = rsp_multi;
                    state_n = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The first cycle after tx_wr ignores tx_busy; the UART may not have raised it yet.
                if (!tx_hold && !tx_busy)
                    state_n = tx_last ? IDLE : TX;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            we_r      <= 1'b0;
            wb_cyc_o  <= 1'b0;
            tx_wr     <= 1'b0;
            tx_data   <= 8'h00;
            rsp_byte  <= 8'h00;
            rsp_multi <= 1'b0;
            tx_last   <= 1'b0;
            tx_hold   <= 1'b0;
            bus_cnt   <= '0;
            rx_cnt    <= '0;
        end else begin
            state   <= state_n;
            tx_wr   <= tx_fire;
            tx_hold <= tx_fire;
            if (we_set)
                we_r <= we_val;
            if (cyc_start)
                wb_cyc_o <= 1'b1;
            else if (cyc_end)
                wb_cyc_o <= 1'b0;
            if (rsp_set) begin
                rsp_byte  <= rsp_val;
                rsp_multi <= rsp_multi_val;
            end
            if (tx_fire) begin
                tx_data <= rsp_multi ? dat_q[31:24] : rsp_byte;
                tx_last <= !rsp_multi || (dat_cnt == 2'd3);
            end
            bus_cnt <= (state == BUS) ? bus_cnt + BW'(1) : '0;
            rx_cnt  <= (rx_take || !in_rx) ? '0 : rx_cnt + RW'(1);
        end
    end

endmodule
